cndm_proto_dma_rd_arb: RTL
==========================

Name: cndm_proto_dma_rd_arb

Overview:
Round-robin arbiter that shares the single host DMA read-descriptor channel between PORTS requesters (per-port TX/RX queue managers and descriptor fetch units).
- On grant, tags each descriptor with the requester index and tracks per-requester outstanding operations against a credit limit.
- Routes DMA read status completions back to the requester that issued them.
- Sits between the core's queue logic and the PCIe DMA interface read-descriptor port.

Parameters:
PORTS, 4, number of requesters (>=2)
PCIE_ADDR_W, 64, host source address width
RAM_ADDR_W, 16, DMA RAM destination address width
RAM_SEL_W, 4, DMA RAM destination select width
LEN_W, 20, transfer length width
REQ_TAG_W, 6, requester-side tag width
TAG_W, 8, DMA-side tag width; must be >= REQ_TAG_W+$clog2(PORTS), checked at elaboration
MAX_OUTSTANDING, 16, per-requester outstanding-operation limit (1..2**REQ_TAG_W)

Ports:
clk  in  1  clock
rst  in  1  reset
s_req_src_addr  in  PORTS*PCIE_ADDR_W  per-requester host address
s_req_dst_sel  in  PORTS*RAM_SEL_W  per-requester RAM select
s_req_dst_addr  in  PORTS*RAM_ADDR_W  per-requester RAM address
s_req_len  in  PORTS*LEN_W  per-requester length
s_req_tag  in  PORTS*REQ_TAG_W  per-requester tag
s_req_valid  in  PORTS  request valid
s_req_ready  out  PORTS  request accepted
m_desc_src_addr  out  PCIE_ADDR_W  to DMA
m_desc_dst_sel  out  RAM_SEL_W  to DMA
m_desc_dst_addr  out  RAM_ADDR_W  to DMA
m_desc_len  out  LEN_W  to DMA
m_desc_tag  out  TAG_W  {zero pad, index, req tag}
m_desc_valid  out  1  descriptor valid
m_desc_ready  in  1  DMA accepts
s_sts_tag  in  TAG_W  completion tag from DMA
s_sts_error  in  4  completion status
s_sts_valid  in  1  completion strobe (no backpressure)
m_sts_tag  out  PORTS*REQ_TAG_W  returned tag
m_sts_error  out  PORTS*4  returned status
m_sts_valid  out  PORTS  one-hot completion strobe
busy  out  PORTS  requester has outstanding ops
stat_bad_sts  out  1  one-cycle pulse: unroutable or unmatched status

Behaviour:
- Clock clk. Reset rst: synchronous, active-high. On reset: m_desc_valid=0, m_sts_valid=0, stat_bad_sts=0, counters=0, busy=0, RR pointer=0. Data outputs are don't-care while their valid is low.
- Eligibility: requester i is eligible when s_req_valid[i] and cnt[i] < MAX_OUTSTANDING.
- Output register is free when !m_desc_valid || m_desc_ready.
- Grant: when the output register is free and any requester is eligible, grant the first eligible index at or after ptr, wrapping modulo PORTS.
  - s_req_ready[grant]=1 combinationally in that cycle; all other ready bits are 0.
  - Next cycle: output register loaded, m_desc_valid=1, ptr=grant+1 mod PORTS.
- Latency: request to m_desc_valid is 1 cycle. Back-to-back grants are allowed while m_desc_ready=1, giving full throughput of 1 descriptor/cycle.
- m_desc_valid holds, with stable data, until m_desc_ready. With no eligible requester and m_desc_ready, m_desc_valid falls.
- Tag: m_desc_tag = TAG_W'({index, s_req_tag[i]}).
- Counter cnt[i] ($clog2(MAX_OUTSTANDING+1) bits):
  - +1 on grant to i.
  - -1 on routed status to i.
  - Simultaneous grant and status for the same i: unchanged.
  - Counters saturate at 0 on decrement.
- busy[i] = (cnt[i] != 0), registered.
- Status routing: idx = s_sts_tag[REQ_TAG_W +: $clog2(PORTS)].
  - If idx < PORTS and cnt[idx] != 0: next cycle m_sts_valid[idx]=1 with m_sts_tag = low REQ_TAG_W bits and the error code. Latency 1 cycle, single-cycle strobe.
  - If idx >= PORTS or cnt[idx] == 0: status is dropped, no counter change, stat_bad_sts pulses 1 cycle.
- Reset mid-operation: in-flight descriptor dropped, counters cleared. Subsequent stale statuses hit the cnt==0 path and pulse stat_bad_sts.

Decomposition:
- Package cndm_proto_dma_pkg holds:
  - typedef struct for the read descriptor (src_addr, dst_sel, dst_addr, len, tag);
  - the 4-bit DMA status code constants (OK, PCIE_ERR, TIMEOUT, etc.);
  - the function computing the tag index field position.
- Sub-module cndm_proto_rr_arb: generic PORTS-wide round-robin arbiter. Inputs request vector and advance strobe; outputs one-hot grant, encoded index, valid. Reusable for the write channel.

Test Plan:
- PORTS=4, only req 2 valid, tag 0x05, m_desc_ready=1 -> s_req_ready=0100 same cycle; next cycle m_desc_valid=1, m_desc_tag=0x85.
- All 4 valid continuously, ready=1 -> grant order 0,1,2,3,0 at one per cycle; each ready bit asserted once per 4 cycles.
- m_desc_ready=0 for 5 cycles with desc pending -> m_desc_* stable, no s_req_ready asserted; ready=1 -> next grant in that cycle.
- MAX_OUTSTANDING=2, req 1 issues 2 with no status -> third held (ready low), others still granted; status tag 0x40 -> m_sts_valid=0010, m_sts_tag=0x00; next cycle req 1 is eligible again.
- Grant to req 0 and status tag 0x03 in the same cycle with cnt[0]=1 -> cnt[0] stays 1, busy[0]=1, m_sts_valid[0]=1.
- Status tag 0x03 with cnt[0]=0 -> no m_sts_valid, stat_bad_sts pulses once; reset asserted during a pending descriptor -> m_desc_valid=0, busy=0000 next cycle.

Source files
------------

// File: rtl/cndm_proto_dma_pkg.sv
// Shared DMA read-channel types, status codes and tag-layout helpers.
package cndm_proto_dma_pkg;

    // Field widths of the stored read descriptor; instances may use narrower ports.
    localparam int unsigned DESC_ADDR_W     = 64;
    localparam int unsigned DESC_SEL_W      = 4;
    localparam int unsigned DESC_RAM_ADDR_W = 16;
    localparam int unsigned DESC_LEN_W      = 20;
    localparam int unsigned DESC_TAG_W      = 8;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0]     src_addr;
        logic [DESC_SEL_W-1:0]      dst_sel;
        logic [DESC_RAM_ADDR_W-1:0] dst_addr;
        logic [DESC_LEN_W-1:0]      len;
        logic [DESC_TAG_W-1:0]      tag;
    } dma_rd_desc_t;

    // DMA completion status codes
    localparam logic [3:0] DMA_ERROR_NONE        = 4'd0;
    localparam logic [3:0] DMA_ERROR_TIMEOUT     = 4'd1;
    localparam logic [3:0] DMA_ERROR_PARITY      = 4'd2;
    localparam logic [3:0] DMA_ERROR_PCIE_CPL_UR = 4'd3;
    localparam logic [3:0] DMA_ERROR_PCIE_CPL_CA = 4'd4;
    localparam logic [3:0] DMA_ERROR_PCIE_FLR    = 4'd5;
    localparam logic [3:0] DMA_ERROR_BAD_TAG     = 4'd6;

    // Requester index sits directly above the requester tag in the DMA tag.
    function automatic int unsigned tag_idx_lsb(input int unsigned req_tag_w);
        return req_tag_w;
    endfunction

    function automatic int unsigned idx_width(input int unsigned ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/cndm_proto_rr_arb.sv
// Generic round-robin arbiter: grants the first request at or after the pointer.
module cndm_proto_rr_arb
    import cndm_proto_dma_pkg::*;
#(
    parameter  int unsigned PORTS = 4,
    localparam int unsigned IDX_W = idx_width(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req,
    input  logic             advance,
    output logic [PORTS-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] j;

    // Scan requests starting at ptr, wrapping modulo PORTS
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        j           = '0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(PORTS)) begin
                sum = sum - (IDX_W+1)'(PORTS);
            end
            j = sum[IDX_W-1:0];
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = j;
            end
        end
        grant = grant_valid ? (PORTS'(1) << grant_idx) : '0;
    end

    // Pointer moves past the granted requester
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            ptr <= (32'(grant_idx) == PORTS - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/cndm_proto_dma_rd_arb.sv
// Shares one DMA read-descriptor channel between PORTS requesters with
// per-requester credit tracking and status routing back by tag index.
module cndm_proto_dma_rd_arb
    import cndm_proto_dma_pkg::*;
#(
    parameter int unsigned PORTS           = 4,
    parameter int unsigned PCIE_ADDR_W     = 64,
    parameter int unsigned RAM_ADDR_W      = 16,
    parameter int unsigned RAM_SEL_W       = 4,
    parameter int unsigned LEN_W           = 20,
    parameter int unsigned REQ_TAG_W       = 6,
    parameter int unsigned TAG_W           = 8,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PORTS*PCIE_ADDR_W-1:0] s_req_src_addr,
    input  logic [PORTS*RAM_SEL_W-1:0]   s_req_dst_sel,
    input  logic [PORTS*RAM_ADDR_W-1:0]  s_req_dst_addr,
    input  logic [PORTS*LEN_W-1:0]       s_req_len,
    input  logic [PORTS*REQ_TAG_W-1:0]   s_req_tag,
    input  logic [PORTS-1:0]             s_req_valid,
    output logic [PORTS-1:0]             s_req_ready,
    output logic [PCIE_ADDR_W-1:0]       m_desc_src_addr,
    output logic [RAM_SEL_W-1:0]         m_desc_dst_sel,
    output logic [RAM_ADDR_W-1:0]        m_desc_dst_addr,
    output logic [LEN_W-1:0]             m_desc_len,
    output logic [TAG_W-1:0]             m_desc_tag,
    output logic                         m_desc_valid,
    input  logic                         m_desc_ready,
    input  logic [TAG_W-1:0]             s_sts_tag,
    input  logic [3:0]                   s_sts_error,
    input  logic                         s_sts_valid,
    output logic [PORTS*REQ_TAG_W-1:0]   m_sts_tag,
    output logic [PORTS*4-1:0]           m_sts_error,
    output logic [PORTS-1:0]             m_sts_valid,
    output logic [PORTS-1:0]             busy,
    output logic                         stat_bad_sts
);

    localparam int unsigned IDX_W   = idx_width(PORTS);
    localparam int unsigned IDX_LSB = tag_idx_lsb(REQ_TAG_W);
    localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);

    if (TAG_W < REQ_TAG_W + IDX_W) begin : g_tag_w_check
        $error("TAG_W cannot hold requester index and requester tag");
    end
    if (PORTS < 2 || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 2**REQ_TAG_W) begin : g_param_check
        $error("PORTS or MAX_OUTSTANDING out of range");
    end
    if (PCIE_ADDR_W > DESC_ADDR_W || RAM_SEL_W > DESC_SEL_W || RAM_ADDR_W > DESC_RAM_ADDR_W ||
        LEN_W > DESC_LEN_W || TAG_W > DESC_TAG_W) begin : g_desc_w_check
        $error("descriptor field wider than dma_rd_desc_t");
    end

    logic [CNT_W-1:0] cnt      [PORTS];
    logic [CNT_W-1:0] cnt_next [PORTS];
    logic [PORTS-1:0] eligible;
    logic [PORTS-1:0] arb_req;
    logic [PORTS-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             out_free;
    logic [IDX_W-1:0] sts_idx;
    logic [PORTS-1:0] sts_hit;
    logic             sts_bad;
    dma_rd_desc_t     desc_d;
    dma_rd_desc_t     desc_q;
    logic             desc_valid_q;

    // Requesters under their credit limit compete only while the output slot is free
    always_comb begin
        out_free = !desc_valid_q || m_desc_ready;
        for (int unsigned i = 0; i < PORTS; i++) begin
            eligible[i] = s_req_valid[i] && (32'(cnt[i]) < MAX_OUTSTANDING);
        end
        arb_req = out_free ? eligible : '0;
    end

    cndm_proto_rr_arb #(
        .PORTS(PORTS)
    ) u_rr_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (arb_req),
        .advance    (grant_valid),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    assign s_req_ready = grant;

    // Select the granted requester's descriptor and prefix its tag with the index
    always_comb begin
        desc_d = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (grant[i]) begin
                desc_d.src_addr = DESC_ADDR_W'(s_req_src_addr[i*PCIE_ADDR_W +: PCIE_ADDR_W]);
                desc_d.dst_sel  = DESC_SEL_W'(s_req_dst_sel[i*RAM_SEL_W +: RAM_SEL_W]);
                desc_d.dst_addr = DESC_RAM_ADDR_W'(s_req_dst_addr[i*RAM_ADDR_W +: RAM_ADDR_W]);
                desc_d.len      = DESC_LEN_W'(s_req_len[i*LEN_W +: LEN_W]);
                desc_d.tag      = DESC_TAG_W'({IDX_W'(i), s_req_tag[i*REQ_TAG_W +: REQ_TAG_W]});
            end
        end
    end

    // Output descriptor register: holds until accepted, reloads on grant
    always_ff @(posedge clk) begin
        if (rst) begin
            desc_valid_q <= 1'b0;
        end else if (grant_valid) begin
            desc_valid_q <= 1'b1;
            desc_q       <= desc_d;
        end else if (m_desc_ready) begin
            desc_valid_q <= 1'b0;
        end
    end

    assign m_desc_valid    = desc_valid_q;
    assign m_desc_src_addr = PCIE_ADDR_W'(desc_q.src_addr);
    assign m_desc_dst_sel  = RAM_SEL_W'(desc_q.dst_sel);
    assign m_desc_dst_addr = RAM_ADDR_W'(desc_q.dst_addr);
    assign m_desc_len      = LEN_W'(desc_q.len);
    assign m_desc_tag      = TAG_W'(desc_q.tag);

    // Route status by index field; drop it when index is unknown or nothing is outstanding
    always_comb begin
        sts_idx = s_sts_tag[IDX_LSB +: IDX_W];
        sts_hit = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (s_sts_valid && sts_idx == IDX_W'(i) && cnt[i] != '0) begin
                sts_hit[i] = 1'b1;
            end
        end
        sts_bad = s_sts_valid && !(|sts_hit);
    end

    // Credit counters: grant and routed status in the same cycle cancel out
    always_comb begin
        for (int unsigned i = 0; i < PORTS; i++) begin
            cnt_next[i] = cnt[i];
            if (grant[i] && !sts_hit[i]) begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end else if (sts_hit[i] && !grant[i]) begin
                cnt_next[i] = cnt[i] - CNT_W'(1);
            end
        end
    end

    // Counter, busy and status-strobe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                cnt[i] <= '0;
            end
            busy         <= '0;
            m_sts_valid  <= '0;
            stat_bad_sts <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                cnt[i]  <= cnt_next[i];
                busy[i] <= (cnt_next[i] != '0);
            end
            m_sts_valid  <= sts_hit;
            stat_bad_sts <= sts_bad;
        end
    end

    // Status payload is broadcast; only the strobed requester consumes it
    always_ff @(posedge clk) begin
        if (s_sts_valid) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                m_sts_tag[i*REQ_TAG_W +: REQ_TAG_W] <= s_sts_tag[REQ_TAG_W-1:0];
                m_sts_error[i*4 +: 4]               <= s_sts_error;
            end
        end
    end

endmodule
